// File: rtl/pdp8_dbrk_pkg.sv
// Shared definitions for the PDP-8 data-break sequencer.
//   state_t   : sequencer states (arbitrate, wait for bus, WC/CA/data cycles)
//   DIR_*     : encoding of the per-device transfer direction bit
//   FIELD0    : memory field holding the word-count / current-address pairs
//   WORD_W    : PDP-8 word width used for WC/CA arithmetic
package pdp8_dbrk_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WC_RD,
    S_WC_WR,
    S_CA_RD,
    S_CA_WR,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic        DIR_READ  = 1'b0;
  localparam logic        DIR_WRITE = 1'b1;
  localparam logic [2:0]  FIELD0    = 3'o0;
  localparam int unsigned WORD_W    = 12;

endpackage

// File: rtl/pdp8_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
//   i_req   : N request bits, bit 0 highest priority
//   o_idx   : index of the winning request (0 when none)
//   o_valid : at least one request is set
module pdp8_prio_enc #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // Scan from the top down so the lowest index overwrites last.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned i = N; i > 0; i--) begin
      if (i_req[i-1]) begin
        o_idx   = IW'(i - 1);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pdp8_dbrk.sv
// Three-cycle data-break sequencer and arbiter.
// Picks the highest-priority break requester, obtains the memory bus from
// the CPU, then runs word-count, current-address and data cycles for it.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_dev_req/dir/wca/field/wdata : per-device request and transfer setup
//   o_dev_ack, o_dev_ovf    : one-cycle completion / word-count-overflow pulses
//   o_dev_rdata             : shared read data, held until the next read
//   o_cpu_brk_req, i_cpu_brk_grant : bus handshake with the CPU
//   o_mem_* / i_mem_*       : memory access port, mem_ack completes an access
module pdp8_dbrk
  import pdp8_dbrk_pkg::*;
#(
  parameter int unsigned NDEV = 4,
  parameter int unsigned AW   = 15,
  parameter int unsigned DW   = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NDEV-1:0]      i_dev_req,
  input  logic [NDEV-1:0]      i_dev_dir,
  input  logic [NDEV*12-1:0]   i_dev_wca,
  input  logic [NDEV*3-1:0]    i_dev_field,
  input  logic [NDEV*DW-1:0]   i_dev_wdata,
  output logic [NDEV-1:0]      o_dev_ack,
  output logic [NDEV-1:0]      o_dev_ovf,
  output logic [DW-1:0]        o_dev_rdata,
  output logic                 o_cpu_brk_req,
  input  logic                 i_cpu_brk_grant,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [AW-1:0]        o_mem_addr,
  output logic [DW-1:0]        o_mem_wdata,
  input  logic [DW-1:0]        i_mem_rdata,
  input  logic                 i_mem_ack
);

  localparam int unsigned IW = (NDEV > 1) ? $clog2(NDEV) : 1;

  state_t              r_state, w_state_next;
  logic [IW-1:0]       r_win, w_enc_idx;
  logic                w_enc_valid;
  logic                r_dir, r_ovf;
  logic [WORD_W-1:0]   r_wca, r_wc, r_ca;
  logic [2:0]          r_field;

  logic [WORD_W-1:0]   w_inc, w_wc_d, w_ca_d, w_ca_loc;
  logic [DW-1:0]       w_win_wdata;

  logic                w_brk_d, w_req_d, w_we_d;
  logic [AW-1:0]       w_addr_d;
  logic [DW-1:0]       w_wdata_d;
  logic [NDEV-1:0]     w_ack_d, w_ovf_d;

  pdp8_prio_enc #(.N(NDEV), .IW(IW)) u_enc (
    .i_req   (i_dev_req),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

  assign w_inc       = i_mem_rdata[WORD_W-1:0] + 12'd1;
  assign w_ca_loc    = r_wca + 12'd1;
  assign w_wc_d      = (r_state == S_WC_RD && i_mem_ack) ? w_inc : r_wc;
  assign w_ca_d      = (r_state == S_CA_RD && i_mem_ack) ? w_inc : r_ca;
  assign w_win_wdata = i_dev_wdata[r_win*DW +: DW];

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_enc_valid) w_state_next = S_WAIT;
      S_WAIT: begin
        if (!i_dev_req[r_win])    w_state_next = S_IDLE;
        else if (i_cpu_brk_grant) w_state_next = S_WC_RD;
      end
      S_WC_RD: if (i_mem_ack) w_state_next = S_WC_WR;
      S_WC_WR: if (i_mem_ack) w_state_next = S_CA_RD;
      S_CA_RD: if (i_mem_ack) w_state_next = S_CA_WR;
      S_CA_WR: if (i_mem_ack) w_state_next = S_DATA;
      S_DATA:  if (i_mem_ack) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: computes the values the output registers take at the next
  // edge from the next state, so every output is a flop yet lines up with
  // the state it belongs to.
  always_comb begin
    w_brk_d   = (w_state_next != S_IDLE);
    w_req_d   = 1'b0;
    w_we_d    = 1'b0;
    w_addr_d  = '0;
    w_wdata_d = '0;
    w_ack_d   = '0;
    w_ovf_d   = '0;
    case (w_state_next)
      S_WC_RD: begin
        w_req_d  = 1'b1;
        w_addr_d = {FIELD0, r_wca};
      end
      S_WC_WR: begin
        w_req_d   = 1'b1;
        w_we_d    = 1'b1;
        w_addr_d  = {FIELD0, r_wca};
        w_wdata_d = w_wc_d;
      end
      S_CA_RD: begin
        w_req_d  = 1'b1;
        w_addr_d = {FIELD0, w_ca_loc};
      end
      S_CA_WR: begin
        w_req_d   = 1'b1;
        w_we_d    = 1'b1;
        w_addr_d  = {FIELD0, w_ca_loc};
        w_wdata_d = w_ca_d;
      end
      S_DATA: begin
        w_req_d  = 1'b1;
        w_we_d   = (r_dir == DIR_WRITE);
        w_addr_d = {r_field, w_ca_d};
        // Device write data is captured once on entry and then held.
        if (r_state == S_DATA)        w_wdata_d = o_mem_wdata;
        else if (r_dir == DIR_WRITE)  w_wdata_d = w_win_wdata;
      end
      S_DONE: begin
        w_ack_d[r_win] = 1'b1;
        w_ovf_d[r_win] = r_ovf;
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cpu_brk_req <= 1'b0;
      o_mem_req     <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_dev_ack     <= '0;
      o_dev_ovf     <= '0;
      o_dev_rdata   <= '0;
      r_win         <= '0;
      r_dir         <= DIR_READ;
      r_wca         <= '0;
      r_field       <= '0;
      r_wc          <= '0;
      r_ca          <= '0;
      r_ovf         <= 1'b0;
    end else begin
      o_cpu_brk_req <= w_brk_d;
      o_mem_req     <= w_req_d;
      o_mem_we      <= w_we_d;
      o_mem_addr    <= w_addr_d;
      o_mem_wdata   <= w_wdata_d;
      o_dev_ack     <= w_ack_d;
      o_dev_ovf     <= w_ovf_d;
      r_wc          <= w_wc_d;
      r_ca          <= w_ca_d;
      if (r_state == S_IDLE && w_enc_valid) begin
        r_win   <= w_enc_idx;
        r_dir   <= i_dev_dir[w_enc_idx];
        r_wca   <= i_dev_wca[w_enc_idx*WORD_W +: WORD_W];
        r_field <= i_dev_field[w_enc_idx*3 +: 3];
      end
      if (r_state == S_WC_RD && i_mem_ack)
        r_ovf <= (w_inc == '0);
      if (r_state == S_DATA && i_mem_ack && r_dir == DIR_READ)
        o_dev_rdata <= i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_pdp8_dbrk.sv
module tb_pdp8_dbrk;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   dev_req = '0;
  logic [3:0]   dev_dir = '0;
  logic [47:0]  dev_wca = '0;
  logic [11:0]  dev_field = '0;
  logic [47:0]  dev_wdata = '0;
  logic [3:0]   dev_ack, dev_ovf;
  logic [11:0]  dev_rdata;
  logic         cpu_brk_req;
  logic         cpu_brk_grant = 1'b0;
  logic         mem_req, mem_we, mem_ack;
  logic [14:0]  mem_addr;
  logic [11:0]  mem_wdata, mem_rdata;

  logic [11:0]  mem [0:32767];
  logic         wait_mode = 1'b0;
  logic [1:0]   wcnt = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pdp8_dbrk #(.NDEV(4), .AW(15), .DW(12)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_dev_req       (dev_req),
    .i_dev_dir       (dev_dir),
    .i_dev_wca       (dev_wca),
    .i_dev_field     (dev_field),
    .i_dev_wdata     (dev_wdata),
    .o_dev_ack       (dev_ack),
    .o_dev_ovf       (dev_ovf),
    .o_dev_rdata     (dev_rdata),
    .o_cpu_brk_req   (cpu_brk_req),
    .i_cpu_brk_grant (cpu_brk_grant),
    .o_mem_req       (mem_req),
    .o_mem_we        (mem_we),
    .o_mem_addr      (mem_addr),
    .o_mem_wdata     (mem_wdata),
    .i_mem_rdata     (mem_rdata),
    .i_mem_ack       (mem_ack)
  );

  // Memory model: two wait cycles per access when wait_mode is set.
  assign mem_ack   = wait_mode ? (wcnt == 2'd2) : 1'b1;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_req && mem_ack && mem_we) mem[mem_addr] = mem_wdata;
  end

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 2'd1;
    else                     wcnt <= '0;
  end

  task automatic setup_dev(input int d, input logic dir, input logic [11:0] wca,
                           input logic [2:0] fld, input logic [11:0] wd);
    dev_dir[d]          = dir;
    dev_wca[d*12 +: 12] = wca;
    dev_field[d*3 +: 3] = fld;
    dev_wdata[d*12 +: 12] = wd;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cpu_brk_req !== 1'b0) begin errors++; $display("FAIL reset_brk: got %b want 0", cpu_brk_req); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 15'o0) begin errors++; $display("FAIL reset_addr: got %o want 0", mem_addr); end
    checks++; if (mem_wdata !== 12'o0) begin errors++; $display("FAIL reset_wdata: got %o want 0", mem_wdata); end
    checks++; if (dev_ack !== 4'b0 || dev_ovf !== 4'b0) begin errors++; $display("FAIL reset_ack_ovf: got %b/%b want 0000/0000", dev_ack, dev_ovf); end
    checks++; if (dev_rdata !== 12'o0) begin errors++; $display("FAIL reset_rdata: got %o want 0", dev_rdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read;
    int n = 0;
    logic brk1 = 1'b0;
    logic [3:0] ack = '0, ovf = '0;
    setup_dev(0, 1'b0, 12'o7750, 3'o0, 12'o0);
    mem[12'o7750] = 12'o7776; mem[12'o7751] = 12'o0377; mem[15'o00400] = 12'o1234;
    cpu_brk_grant = 1'b1;
    @(negedge clk);
    dev_req[0] = 1'b1;
    for (int c = 1; c <= 40 && n == 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) brk1 = cpu_brk_req;
      if (dev_ack != 4'b0) begin n = c; ack = dev_ack; ovf = dev_ovf; dev_req[0] = 1'b0; end
    end
    checks++; if (brk1 !== 1'b1) begin errors++; $display("FAIL read_brk_rise: got %b want 1", brk1); end
    checks++; if (n != 7) begin errors++; $display("FAIL read_latency: got %0d want 7", n); end
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL read_ack: got %b want 0001", ack); end
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL read_ovf: got %b want 0000", ovf); end
    checks++; if (dev_rdata !== 12'o1234) begin errors++; $display("FAIL read_data: got %o want 1234", dev_rdata); end
    checks++; if (mem[12'o7750] !== 12'o7777) begin errors++; $display("FAIL read_wc: got %o want 7777", mem[12'o7750]); end
    checks++; if (mem[12'o7751] !== 12'o0400) begin errors++; $display("FAIL read_ca: got %o want 0400", mem[12'o7751]); end
    @(posedge clk); #1;
    checks++; if (dev_ack !== 4'b0 || cpu_brk_req !== 1'b0) begin errors++; $display("FAIL read_after_done: got ack=%b brk=%b want 0000/0", dev_ack, cpu_brk_req); end
    @(negedge clk);
  endtask

  task automatic test_overflow_wrap;
    int n = 0;
    logic [3:0] ack = '0, ovf = '0;
    setup_dev(0, 1'b1, 12'o7750, 3'o3, 12'o5555);
    mem[12'o7750] = 12'o7777; mem[12'o7751] = 12'o7777; mem[15'o30000] = 12'o0;
    cpu_brk_grant = 1'b1;
    @(negedge clk);
    dev_req[0] = 1'b1;
    for (int c = 1; c <= 40 && n == 0; c++) begin
      @(posedge clk); #1;
      if (dev_ack != 4'b0) begin n = c; ack = dev_ack; ovf = dev_ovf; dev_req[0] = 1'b0; end
    end
    checks++; if (n != 7) begin errors++; $display("FAIL ovf_latency: got %0d want 7", n); end
    checks++; if (ack !== 4'b0001 || ovf !== 4'b0001) begin errors++; $display("FAIL ovf_pulse: got ack=%b ovf=%b want 0001/0001", ack, ovf); end
    checks++; if (mem[12'o7750] !== 12'o0000) begin errors++; $display("FAIL ovf_wc: got %o want 0000", mem[12'o7750]); end
    checks++; if (mem[12'o7751] !== 12'o0000) begin errors++; $display("FAIL ovf_ca: got %o want 0000", mem[12'o7751]); end
    checks++; if (mem[15'o30000] !== 12'o5555) begin errors++; $display("FAIL ovf_data: got %o want 5555", mem[15'o30000]); end
    @(posedge clk); #1;
    checks++; if (dev_ovf !== 4'b0) begin errors++; $display("FAIL ovf_one_cycle: got %b want 0000", dev_ovf); end
    @(negedge clk);
  endtask

  task automatic test_priority;
    int n1 = 0, n2 = 0;
    logic [3:0] ack1 = '0, ack2 = '0;
    logic brk_gap = 1'b1;
    setup_dev(1, 1'b0, 12'o0100, 3'o0, 12'o0);
    setup_dev(2, 1'b1, 12'o0200, 3'o1, 12'o4321);
    mem[12'o0100] = 12'o0000; mem[12'o0101] = 12'o0500; mem[15'o00501] = 12'o7070;
    mem[12'o0200] = 12'o7770; mem[12'o0201] = 12'o0600; mem[15'o10601] = 12'o0;
    cpu_brk_grant = 1'b1;
    @(negedge clk);
    dev_req[2] = 1'b1; dev_req[1] = 1'b1;
    for (int c = 1; c <= 40 && n1 == 0; c++) begin
      @(posedge clk); #1;
      if (dev_ack != 4'b0) begin n1 = c; ack1 = dev_ack; dev_req[1] = 1'b0; end
    end
    @(posedge clk); #1;
    brk_gap = cpu_brk_req;
    for (int c = 1; c <= 40 && n2 == 0; c++) begin
      @(posedge clk); #1;
      if (dev_ack != 4'b0) begin n2 = c; ack2 = dev_ack; dev_req[2] = 1'b0; end
    end
    checks++; if (ack1 !== 4'b0010) begin errors++; $display("FAIL prio_first: got %b want 0010", ack1); end
    checks++; if (dev_rdata !== 12'o7070) begin errors++; $display("FAIL prio_rdata: got %o want 7070", dev_rdata); end
    checks++; if (brk_gap !== 1'b0) begin errors++; $display("FAIL prio_brk_gap: got %b want 0", brk_gap); end
    checks++; if (ack2 !== 4'b0100 || n2 != 7) begin errors++; $display("FAIL prio_second: got ack=%b lat=%0d want 0100/7", ack2, n2); end
    checks++; if (mem[12'o0101] !== 12'o0501 || mem[12'o0200] !== 12'o7771) begin errors++; $display("FAIL prio_wcca: got %o/%o want 0501/7771", mem[12'o0101], mem[12'o0200]); end
    checks++; if (mem[15'o10601] !== 12'o4321) begin errors++; $display("FAIL prio_wdata: got %o want 4321", mem[15'o10601]); end
    @(negedge clk);
  endtask

  task automatic test_withdraw;
    int reqs = 0, acks = 0;
    logic brk1 = 1'b0;
    setup_dev(0, 1'b0, 12'o7750, 3'o0, 12'o0);
    cpu_brk_grant = 1'b0;
    @(negedge clk);
    dev_req[0] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) brk1 = cpu_brk_req;
      if (c == 3) dev_req[0] = 1'b0;
      if (mem_req) reqs++;
      if (dev_ack != 4'b0) acks++;
    end
    checks++; if (brk1 !== 1'b1) begin errors++; $display("FAIL wd_brk_rise: got %b want 1", brk1); end
    checks++; if (cpu_brk_req !== 1'b0) begin errors++; $display("FAIL wd_brk_drop: got %b want 0", cpu_brk_req); end
    checks++; if (reqs != 0 || acks != 0) begin errors++; $display("FAIL wd_no_access: got req=%0d ack=%0d want 0/0", reqs, acks); end
    cpu_brk_grant = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wait_states;
    int n = 0, viol = 0;
    logic pend = 1'b0;
    logic [14:0] pa = '0;
    logic [11:0] pw = '0;
    logic pwe = 1'b0;
    setup_dev(0, 1'b0, 12'o1000, 3'o0, 12'o0);
    mem[12'o1000] = 12'o0010; mem[12'o1001] = 12'o2000; mem[15'o02001] = 12'o0707;
    wait_mode = 1'b1;
    cpu_brk_grant = 1'b1;
    @(negedge clk);
    dev_req[0] = 1'b1;
    for (int c = 1; c <= 60 && n == 0; c++) begin
      @(posedge clk); #1;
      if (pend && (mem_addr !== pa || mem_we !== pwe || mem_wdata !== pw)) viol++;
      pend = mem_req && !mem_ack; pa = mem_addr; pwe = mem_we; pw = mem_wdata;
      if (dev_ack != 4'b0) begin n = c; dev_req[0] = 1'b0; end
    end
    checks++; if (n != 17) begin errors++; $display("FAIL ws_latency: got %0d want 17", n); end
    checks++; if (viol != 0) begin errors++; $display("FAIL ws_stable: got %0d changes want 0", viol); end
    checks++; if (dev_rdata !== 12'o0707) begin errors++; $display("FAIL ws_rdata: got %o want 0707", dev_rdata); end
    checks++; if (mem[12'o1000] !== 12'o0011 || mem[12'o1001] !== 12'o2001) begin errors++; $display("FAIL ws_wcca: got %o/%o want 0011/2001", mem[12'o1000], mem[12'o1001]); end
    wait_mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n = 0;
    setup_dev(0, 1'b0, 12'o3000, 3'o0, 12'o0);
    mem[12'o3000] = 12'o0005; mem[12'o3001] = 12'o0100;
    cpu_brk_grant = 1'b1;
    @(negedge clk);
    dev_req[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 15'o03001 || mem_we !== 1'b0) begin errors++; $display("FAIL mid_ca_rd: got req=%b addr=%o we=%b want 1/03001/0", mem_req, mem_addr, mem_we); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (cpu_brk_req !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 15'o0 || dev_ack !== 4'b0) begin errors++; $display("FAIL mid_async_clear: got brk=%b req=%b we=%b addr=%o ack=%b want all 0", cpu_brk_req, mem_req, mem_we, mem_addr, dev_ack); end
    checks++; if (mem[12'o3000] !== 12'o0006 || mem[12'o3001] !== 12'o0100) begin errors++; $display("FAIL mid_partial: got %o/%o want 0006/0100", mem[12'o3000], mem[12'o3001]); end
    dev_req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem[12'o3000] = 12'o7000; mem[12'o3001] = 12'o0100; mem[15'o00101] = 12'o2222;
    @(negedge clk);
    dev_req[0] = 1'b1;
    for (int c = 1; c <= 40 && n == 0; c++) begin
      @(posedge clk); #1;
      if (dev_ack != 4'b0) begin n = c; dev_req[0] = 1'b0; end
    end
    checks++; if (n != 7 || dev_rdata !== 12'o2222) begin errors++; $display("FAIL mid_recover: got lat=%0d rdata=%o want 7/2222", n, dev_rdata); end
    checks++; if (mem[12'o3000] !== 12'o7001 || mem[12'o3001] !== 12'o0101) begin errors++; $display("FAIL mid_recover_wcca: got %o/%o want 7001/0101", mem[12'o3000], mem[12'o3001]); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_overflow_wrap();
    test_priority();
    test_withdraw();
    test_wait_states();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
